load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly upstream of the processor's word-wide data RAM (32-bit words, asynchronous read, synchronous write, 14-bit word address).
- Accepts byte, halfword and word load/store requests from the memory pipeline stage and drives the RAM's enable, write, address and write-data pins.
- Converts sub-word stores into a two-cycle read-modify-write.
- Registers load data, applying lane extraction and sign/zero extension.
- Flags misaligned accesses.

Parameters:
- WIDTH, 32, data word width; fixed lane logic assumes 32.
- ADDR_BITS, 16, byte-address width of requests.
- RAM_ADDR_BITS, 14, word-address width driven to the RAM; equals ADDR_BITS-2.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; transfer when req_valid&&req_ready
- req_write  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend
- req_addr  in  ADDR_BITS  byte address, little-endian lanes
- req_wdata  in  WIDTH  store data, right-justified
- resp_valid  out  1  one-cycle pulse, load data valid
- resp_rdata  out  WIDTH  extended load data
- misalign_err  out  1  one-cycle pulse for a rejected request
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write
- ram_addr  out  RAM_ADDR_BITS  req_addr[ADDR_BITS-1:2]
- ram_wdata  out  WIDTH  word to write
- ram_rdata  in  WIDTH  RAM asynchronous read data

Behaviour:
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, misalign_err=0, ram_en=0, ram_we=0. Reset in MERGE aborts the pending store: no write issued.
- States: IDLE, MERGE. req_ready=1 only in IDLE.
- Misaligned request:
  - Conditions: half with addr[0]=1; word with addr[1:0]!=0; size=11.
  - ram_en=0 that cycle.
  - Next cycle: misalign_err=1, resp_valid=0.
  - State stays IDLE.
- Load accepted in IDLE:
  - ram_en=1, ram_we=0, ram_addr driven combinationally.
  - At the edge, the extracted lane is captured into resp_rdata.
  - Next cycle: resp_valid=1. Latency is one cycle; back-to-back loads give one response per cycle.
  - Lane extraction: byte = word[8*a+7:8*a], a=addr[1:0]; half = word[16*h+15:16*h], h=addr[1]; then sign- or zero-extend to 32.
- Word store accepted in IDLE: ram_en=1, ram_we=1, ram_wdata=req_wdata in the same cycle. Stays IDLE; no response.
- Sub-word store accepted in IDLE:
  - Read cycle: ram_en=1, ram_we=0. At the edge, latch rmw_word=ram_rdata plus addr, size and data. Go to MERGE.
  - MERGE: ram_en=1, ram_we=1, ram_addr=latched address, ram_wdata=rmw_word with the selected lane(s) replaced by req_wdata[7:0] or [15:0]. req_ready=0. Go to IDLE.
  - Total occupancy is 2 cycles.
- resp_rdata holds its last value between responses.
- req_valid=0: RAM outputs idle (ram_en=0).
- A request offered during MERGE is not accepted; the requester must hold it.
- The RAM is never written twice for one request.

Optional Feature:
- Macro: LSU_MMIO_EN.
- When defined:
  - Adds ports io_out (out, WIDTH, register) and io_in (in, WIDTH).
  - Accesses with req_addr[ADDR_BITS-1]=1 bypass the RAM (ram_en=0).
  - Word store writes io_out (reset 0).
  - Word load returns io_in with the same one-cycle resp_valid timing.
  - Sub-word MMIO accesses raise misalign_err.
- When undefined: no io ports; the full address space maps to RAM with the top bit ignored.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
  - state encoding ST_IDLE/ST_MERGE
  - MMIO_SEL_BIT constant
- Sub-module lsu_lane_align, purely combinational, used by both paths:
  - extract+extend for loads
  - merge for stores

Test Plan:
- Word store addr 0x0010 data 0xDEADBEEF, then word load 0x0010 -> ram_we pulse with ram_addr=0x0004; next-cycle resp_valid, resp_rdata=0xDEADBEEF.
- Byte store 0x55 to addr 0x0012 over word 0xDEADBEEF -> req_ready low 1 cycle; MERGE writes 0xDE55BEEF; signed byte load 0x0012 gives 0x00000055, signed byte load 0x0013 gives 0xFFFFFFDE.
- Half load addr 0x0011 -> no ram_en; misalign_err=1 next cycle, resp_valid=0; word load addr 0x0002 and size=11 behave the same.
- Unsigned half load 0x0012 of 0xDE55BEEF -> 0x0000DE55; signed -> 0xFFFFDE55; back-to-back loads 0x0010, 0x0012 -> two consecutive resp_valid cycles.
- Sub-word store accepted, then reset asserted during MERGE -> ram_we stays 0, RAM word unchanged, outputs at reset values.
- LSU_MMIO_EN: word store 0x12345678 to 0x8000 -> io_out=0x12345678, ram_en=0; word load 0x8000 with io_in=0xCAFEF00D -> resp_rdata=0xCAFEF00D.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states,
// MMIO window select bit and the alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_e;

  localparam int MMIO_SEL_BIT = 15;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extract+extend for loads, lane merge for
// the write half of a sub-word read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_addr,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  output logic [31:0] ld_data,
  input  logic [31:0] st_word,
  input  logic [1:0]  st_addr,
  input  logic [1:0]  st_size,
  input  logic [15:0] st_data,
  output logic [31:0] st_merged
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ld_word[{ld_addr, 3'b000} +: 8];
    ld_half = ld_word[{ld_addr[1], 4'b0000} +: 16];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  always_comb begin
    st_merged = st_word;
    if (st_size == SZ_HALF)
      st_merged[{st_addr[1], 4'b0000} +: 16] = st_data;
    else
      st_merged[{st_addr, 3'b000} +: 8] = st_data[7:0];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end for the word-wide data RAM; sub-word stores become a
// two-cycle read-modify-write. Define LSU_MMIO_EN for the io_in/io_out window.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int ADDR_BITS     = 16,
  parameter int RAM_ADDR_BITS = 14
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef LSU_MMIO_EN
  output logic [WIDTH-1:0]         io_out,
  input  logic [WIDTH-1:0]         io_in,
`endif
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_signed,
  input  logic [ADDR_BITS-1:0]     req_addr,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     resp_valid,
  output logic [WIDTH-1:0]         resp_rdata,
  output logic                     misalign_err,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [WIDTH-1:0]         ram_wdata,
  input  logic [WIDTH-1:0]         ram_rdata
);

  state_e               state, state_nxt;
  logic [ADDR_BITS-1:0] lat_addr;
  logic [1:0]           lat_size;
  logic [15:0]          lat_data;
  logic [WIDTH-1:0]     rmw_word;
  logic [WIDTH-1:0]     ld_data, st_merged;
  logic is_io, bad, accept, do_load, do_wstore, do_sstore;

`ifdef LSU_MMIO_EN
  assign is_io = req_addr[MMIO_SEL_BIT];
`else
  assign is_io = 1'b0;
`endif

  // MMIO only supports whole-word accesses
  assign bad       = misaligned(req_size, req_addr[1:0]) || (is_io && req_size != SZ_WORD);
  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign do_load   = accept && !bad && !req_write;
  assign do_wstore = accept && !bad && req_write && (req_size == SZ_WORD);
  assign do_sstore = accept && !bad && req_write && (req_size != SZ_WORD);

  lsu_lane_align u_align (
    .ld_word   (ram_rdata),
    .ld_addr   (req_addr[1:0]),
    .ld_size   (req_size),
    .ld_signed (req_signed),
    .ld_data   (ld_data),
    .st_word   (rmw_word),
    .st_addr   (lat_addr[1:0]),
    .st_size   (lat_size),
    .st_data   (lat_data),
    .st_merged (st_merged)
  );

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = req_addr[ADDR_BITS-1:2];
    ram_wdata = req_wdata;
    case (state)
      ST_IDLE: begin
        if (accept && !bad && !is_io) begin
          ram_en = 1'b1;
          ram_we = do_wstore;
        end
        if (do_sstore) state_nxt = ST_MERGE;
      end
      ST_MERGE: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = lat_addr[ADDR_BITS-1:2];
        ram_wdata = st_merged;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // reset must suppress the MERGE write in the same cycle, not after it
    if (reset) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      resp_valid   <= do_load;
      misalign_err <= accept && bad;
      if (do_load) begin
`ifdef LSU_MMIO_EN
        resp_rdata <= is_io ? io_in : ld_data;
`else
        resp_rdata <= ld_data;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_sstore) begin
      rmw_word <= ram_rdata;
      lat_addr <= req_addr;
      lat_size <= req_size;
      lat_data <= req_wdata[15:0];
    end
  end

`ifdef LSU_MMIO_EN
  always_ff @(posedge clk) begin
    if (reset)                  io_out <= '0;
    else if (do_wstore && is_io) io_out <= req_wdata;
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// async-read / sync-write RAM model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, misalign_err;
  logic [31:0] resp_rdata;
  logic        ram_en, ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
`ifdef LSU_MMIO_EN
  logic [31:0] io_out, io_in;
`endif

  logic [31:0] mem [0:16383];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;

  load_store_unit dut (
    .clk(clk), .reset(reset),
`ifdef LSU_MMIO_EN
    .io_out(io_out), .io_in(io_in),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .misalign_err(misalign_err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [15:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_signed = sg; req_addr = addr; req_wdata = wd;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  // advance to the next negedge, where registered outputs are sampled
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
`ifdef LSU_MMIO_EN
    io_in = 32'hCAFE_F00D;
`endif
    reset = 1'b1;
    idle();
    step();
    step();
    check("rst_ready",    32'(req_ready), 32'd1);
    check("rst_resp_vld", 32'(resp_valid), 32'd0);
    check("rst_rdata",    resp_rdata, 32'h0);
    check("rst_mis",      32'(misalign_err), 32'd0);
    check("rst_ram_en",   32'(ram_en), 32'd0);
    check("rst_ram_we",   32'(ram_we), 32'd0);
    reset = 1'b0;

    // word store then word load
    drive(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEAD_BEEF);
    #1;
    check("wst_en",    32'(ram_en), 32'd1);
    check("wst_we",    32'(ram_we), 32'd1);
    check("wst_addr",  32'(ram_addr), 32'h4);
    check("wst_wdata", ram_wdata, 32'hDEAD_BEEF);
    step();
    check("wst_no_resp", 32'(resp_valid), 32'd0);
    drive(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0);
    #1;
    check("wld_en", 32'(ram_en), 32'd1);
    check("wld_we", 32'(ram_we), 32'd0);
    step();
    check("wld_vld",   32'(resp_valid), 32'd1);
    check("wld_rdata", resp_rdata, 32'hDEAD_BEEF);

    // byte store 0x55 to 0x12; a load is offered during MERGE and held
    drive(1'b1, 2'b00, 1'b0, 16'h0012, 32'h0000_0055);
    #1;
    check("bst_rd_en", 32'(ram_en), 32'd1);
    check("bst_rd_we", 32'(ram_we), 32'd0);
    step();
    drive(1'b0, 2'b00, 1'b1, 16'h0012, 32'h0);
    #1;
    check("mrg_ready", 32'(req_ready), 32'd0);
    check("mrg_we",    32'(ram_we), 32'd1);
    check("mrg_addr",  32'(ram_addr), 32'h4);
    check("mrg_wdata", ram_wdata, 32'hDE55_BEEF);
    step();
    check("mrg_no_resp", 32'(resp_valid), 32'd0);
    check("mrg_mem",     mem[4], 32'hDE55_BEEF);
    #1;
    check("held_ld_en", 32'(ram_en), 32'd1);
    step();
    check("sb12_vld",   32'(resp_valid), 32'd1);
    check("sb12_rdata", resp_rdata, 32'h0000_0055);
    drive(1'b0, 2'b00, 1'b1, 16'h0013, 32'h0);
    step();
    check("sb13_rdata", resp_rdata, 32'hFFFF_FFDE);
    drive(1'b0, 2'b01, 1'b0, 16'h0012, 32'h0);
    step();
    check("uh12_rdata", resp_rdata, 32'h0000_DE55);
    drive(1'b0, 2'b01, 1'b1, 16'h0012, 32'h0);
    step();
    check("sh12_rdata", resp_rdata, 32'hFFFF_DE55);

    // back-to-back loads
    drive(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0);
    step();
    check("b2b0_vld",   32'(resp_valid), 32'd1);
    check("b2b0_rdata", resp_rdata, 32'hDE55_BEEF);
    drive(1'b0, 2'b01, 1'b0, 16'h0012, 32'h0);
    step();
    check("b2b1_vld",   32'(resp_valid), 32'd1);
    check("b2b1_rdata", resp_rdata, 32'h0000_DE55);
    idle();
    step();
    check("idle_vld",  32'(resp_valid), 32'd0);
    check("idle_hold", resp_rdata, 32'h0000_DE55);

    // misaligned requests
    drive(1'b0, 2'b01, 1'b0, 16'h0011, 32'h0);
    #1;
    check("mis_h_en", 32'(ram_en), 32'd0);
    step();
    check("mis_h_err", 32'(misalign_err), 32'd1);
    check("mis_h_vld", 32'(resp_valid), 32'd0);
    drive(1'b0, 2'b10, 1'b0, 16'h0002, 32'h0);
    #1;
    check("mis_w_en", 32'(ram_en), 32'd0);
    step();
    check("mis_w_err", 32'(misalign_err), 32'd1);
    drive(1'b0, 2'b11, 1'b0, 16'h0010, 32'h0);
    #1;
    check("mis_r_en", 32'(ram_en), 32'd0);
    step();
    check("mis_r_err", 32'(misalign_err), 32'd1);
    check("mis_r_vld", 32'(resp_valid), 32'd0);
    drive(1'b1, 2'b01, 1'b0, 16'h0013, 32'h0000_1234);
    #1;
    check("mis_st_en", 32'(ram_en), 32'd0);
    step();
    check("mis_st_err", 32'(misalign_err), 32'd1);
    check("mis_st_mem", mem[4], 32'hDE55_BEEF);
    idle();
    step();
    check("mis_clear", 32'(misalign_err), 32'd0);

    // halfword store to the low lane
    drive(1'b1, 2'b01, 1'b0, 16'h0010, 32'hFFFF_A5A5);
    step();
    idle();
    #1;
    check("hst_wdata", ram_wdata, 32'hDE55_A5A5);
    step();
    check("hst_mem", mem[4], 32'hDE55_A5A5);

    // reset during MERGE aborts the write
    drive(1'b1, 2'b00, 1'b0, 16'h0011, 32'h0000_0077);
    step();
    idle();
    reset = 1'b1;
    #1;
    check("rmrg_we", 32'(ram_we), 32'd0);
    check("rmrg_en", 32'(ram_en), 32'd0);
    step();
    check("rmrg_mem",   mem[4], 32'hDE55_A5A5);
    check("rmrg_ready", 32'(req_ready), 32'd1);
    check("rmrg_rdata", resp_rdata, 32'h0);
    check("rmrg_vld",   32'(resp_valid), 32'd0);
    reset = 1'b0;
    step();
    check("rmrg_idle_we", 32'(ram_we), 32'd0);

`ifdef LSU_MMIO_EN
    drive(1'b1, 2'b10, 1'b0, 16'h8000, 32'h1234_5678);
    #1;
    check("io_st_en", 32'(ram_en), 32'd0);
    step();
    check("io_out", io_out, 32'h1234_5678);
    drive(1'b0, 2'b10, 1'b0, 16'h8000, 32'h0);
    #1;
    check("io_ld_en", 32'(ram_en), 32'd0);
    step();
    check("io_ld_vld",   32'(resp_valid), 32'd1);
    check("io_ld_rdata", resp_rdata, 32'hCAFE_F00D);
    drive(1'b0, 2'b00, 1'b0, 16'h8000, 32'h0);
    step();
    check("io_sub_err", 32'(misalign_err), 32'd1);
    idle();
    step();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
